// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared constants and types for the machine-mode CSR file and the trap
// sequencer:
//   - CSR address constants for the implemented machine-mode registers
//   - bit indices of the interrupt-enable and pending fields
//   - writable-bit masks applied to every CSR write
//   - funct3 encodings of the CSR instructions
//   - interrupt cause values written to mcause on trap entry
//   - trap_state_t, the RUN/SLEEP sequencer state
//   - csrNewValue, the read-modify-write combiner for CSR instructions
// ---------------------------------------------------------------------------
package csr_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Field positions inside mstatus and mie/mip
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MTIE_BIT     = 7;
    localparam int MIE_MEIE_BIT     = 11;

    // Writable bits of each storage CSR; everything else reads as zero
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0880;
    localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] MCAUSE_WMASK  = 32'hFFFF_FFFF;

    // funct3 encodings of the CSR instructions
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // Interrupt cause values (interrupt flag in bit 31)
    localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;

    // Trap sequencer state
    typedef enum logic {
        RUN   = 1'b0,
        SLEEP = 1'b1
    } trap_state_t;

    // Combines the old CSR value with the operand according to the CSR op.
    // The immediate forms arrive already zero-extended, so they share the
    // register forms' arithmetic. Unknown encodings leave the value as is,
    // which makes the write a no-op.
    function automatic logic [31:0] csrNewValue(
        input logic [2:0]  funct3,
        input logic [31:0] oldValue,
        input logic [31:0] operand
    );
        logic [31:0] result;
        case (funct3)
            F3_CSRRW, F3_CSRRWI: result = operand;
            F3_CSRRS, F3_CSRRSI: result = oldValue | operand;
            F3_CSRRC, F3_CSRRCI: result = oldValue & ~operand;
            default:             result = oldValue;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/irq_prio.sv
// ---------------------------------------------------------------------------
// irq_prio
// Combinational interrupt arbitration. Combines the enable bits held in mie
// with the live pending bits in mip to decide whether the core should wake
// from wfi, whether an interrupt must be taken now, and which cause to
// report. External interrupts win over the timer.
//
// Ports:
//   mstatus_mie_i  in   1   global machine interrupt enable (mstatus.MIE)
//   mie_i          in  32   mie register contents
//   mip_i          in  32   mip value built from the interrupt levels
//   irq_pend_o     out  1   an enabled interrupt is pending and MIE is set
//   wake_o         out  1   an enabled interrupt is pending, ignoring MIE
//   cause_o        out 32   mcause value for the winning interrupt
// ---------------------------------------------------------------------------
module irq_prio
    import csr_pkg::*;
(
    input  logic        mstatus_mie_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mip_i,
    output logic        irq_pend_o,
    output logic        wake_o,
    output logic [31:0] cause_o
);

    logic [31:0] enabledPending;
    logic        extHit;
    logic        timerHit;

    assign enabledPending = mie_i & mip_i;
    assign extHit         = enabledPending[MIE_MEIE_BIT];
    assign timerHit       = enabledPending[MIE_MTIE_BIT];

    // wfi wake-up deliberately ignores the global enable so that a core
    // sleeping with interrupts masked still resumes on an enabled source.
    assign wake_o     = |enabledPending;
    assign irq_pend_o = mstatus_mie_i & wake_o;

    // Fixed priority: external first, timer otherwise.
    assign cause_o = extHit ? CAUSE_M_EXT : CAUSE_M_TIMER;

    // timerHit only documents the fallback arm of the priority mux.
    logic unusedTimerHit;
    assign unusedTimerHit = timerHit;

endmodule

// File: rtl/trap_csr_unit.sv
// ---------------------------------------------------------------------------
// trap_csr_unit
// Machine-mode CSR file and trap sequencer for the single-cycle core.
// Executes CSR instructions, takes interrupts, returns with mret and parks
// the core in wfi until an enabled interrupt arrives. Redirect, flush and
// stall are combinational in the decode cycle; all state changes land on
// the next rising clock edge.
//
// Ports:
//   clk          in   1   core clock
//   rst_n        in   1   asynchronous active-low reset
//   csr_w_en     in   1   decoded CSR instruction this cycle
//   csr_funct3   in   3   CSR op encoding
//   csr_addr     in  12   CSR address
//   csr_wdata    in  32   rs1 value or zero-extended zimm
//   ret          in   1   decoded mret
//   wfi          in   1   decoded wfi
//   pc           in  32   PC of the current instruction
//   ext_irq      in   1   external interrupt level
//   timer_irq    in   1   timer interrupt level
//   csr_rdata    out 32   old value of the addressed CSR
//   redirect_en  out  1   fetch takes redirect_pc next
//   redirect_pc  out 32   trap vector or mepc
//   flush        out  1   current instruction must not commit
//   stall        out  1   hold PC, commit nothing
// ---------------------------------------------------------------------------
module trap_csr_unit
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_w_en,
    input  logic [2:0]      csr_funct3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            ret,
    input  logic            wfi,
    input  logic [XLEN-1:0] pc,
    input  logic            ext_irq,
    input  logic            timer_irq,
    output logic [XLEN-1:0] csr_rdata,
    output logic            redirect_en,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            stall
);

    // CSR storage and sequencer state
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q,     mie_d;
    logic [31:0] mtvec_q,   mtvec_d;
    logic [31:0] mepc_q,    mepc_d;
    logic [31:0] mcause_q,  mcause_d;
    trap_state_t state_q,   state_d;

    logic [31:0] mipValue;
    logic [31:0] csrOld;
    logic [31:0] csrNew;
    logic        irqPend;
    logic        wake;
    logic [31:0] irqCause;

    logic        inRun;
    logic        takeTrap;
    logic        doRet;
    logic        doSleep;
    logic        doCsrWrite;

    // mip is not stored: it mirrors the interrupt levels directly.
    assign mipValue = {20'b0, ext_irq, 3'b0, timer_irq, 7'b0};

    irq_prio u_irq_prio (
        .mstatus_mie_i (mstatus_q[MSTATUS_MIE_BIT]),
        .mie_i         (mie_q),
        .mip_i         (mipValue),
        .irq_pend_o    (irqPend),
        .wake_o        (wake),
        .cause_o       (irqCause)
    );

    // Read mux: returns the pre-write value of the addressed CSR;
    // unimplemented addresses read as zero.
    always_comb begin
        csrOld = '0;
        case (csr_addr)
            CSR_MSTATUS: csrOld = mstatus_q;
            CSR_MIE:     csrOld = mie_q;
            CSR_MTVEC:   csrOld = mtvec_q;
            CSR_MEPC:    csrOld = mepc_q;
            CSR_MCAUSE:  csrOld = mcause_q;
            CSR_MIP:     csrOld = mipValue;
            default:     csrOld = '0;
        endcase
    end

    assign csr_rdata = csrOld;
    assign csrNew    = csrNewValue(csr_funct3, csrOld, csr_wdata);

    // A pending interrupt pre-empts whatever instruction sits in decode, so
    // every other action is qualified with ~irqPend. In SLEEP all decode
    // strobes are ignored.
    assign inRun      = (state_q == RUN);
    assign takeTrap   = inRun & irqPend;
    assign doRet      = inRun & ~irqPend & ret;
    assign doSleep    = inRun & ~irqPend & wfi & ~wake;
    assign doCsrWrite = inRun & ~irqPend & csr_w_en;

    assign redirect_en = takeTrap | doRet;
    assign flush       = takeTrap;
    assign redirect_pc = takeTrap ? {mtvec_q[31:2], 2'b00} : mepc_q;
    assign stall       = inRun ? doSleep : ~wake;

    // Next-state logic. Order matters: an mret overrides a CSR write to
    // mstatus, and a trap overrides everything (the other actions are
    // already gated off when a trap is taken).
    always_comb begin
        mstatus_d = mstatus_q;
        mie_d     = mie_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        state_d   = state_q;

        if (doCsrWrite) begin
            case (csr_addr)
                CSR_MSTATUS: mstatus_d = csrNew & MSTATUS_WMASK;
                CSR_MIE:     mie_d     = csrNew & MIE_WMASK;
                CSR_MTVEC:   mtvec_d   = csrNew & MTVEC_WMASK;
                CSR_MEPC:    mepc_d    = csrNew & MEPC_WMASK;
                CSR_MCAUSE:  mcause_d  = csrNew & MCAUSE_WMASK;
                default:     ;
            endcase
        end

        if (doRet) begin
            mstatus_d[MSTATUS_MIE_BIT]  = mstatus_q[MSTATUS_MPIE_BIT];
            mstatus_d[MSTATUS_MPIE_BIT] = 1'b1;
        end

        if (takeTrap) begin
            mepc_d                      = pc & MEPC_WMASK;
            mcause_d                    = irqCause;
            mstatus_d[MSTATUS_MPIE_BIT] = mstatus_q[MSTATUS_MIE_BIT];
            mstatus_d[MSTATUS_MIE_BIT]  = 1'b0;
        end

        case (state_q)
            RUN:     if (doSleep) state_d = SLEEP;
            SLEEP:   if (wake)    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q <= '0;
            mie_q     <= '0;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            state_q   <= RUN;
        end else begin
            mstatus_q <= mstatus_d;
            mie_q     <= mie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            state_q   <= state_d;
        end
    end

endmodule
